// File: rtl/demux_1a2_fifo_pkg.sv
// Shared defaults, lane indices and pointer sizing for the 1:2 demultiplexer FIFO slice.
package demux_pkg;

  localparam int unsigned DEF_DATA_W = 2;
  localparam int unsigned DEF_DEPTH  = 2;
  localparam int unsigned DEF_CNT_W  = 6;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/demux_1a2_fifo_if.sv
// Upstream push port and the two downstream lane ports of the demultiplexer.
interface demux_1a2_fifo_if
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  logic              valid_in;
  logic              selector;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out0;
  logic              valid_out1;
  logic              ready_out0;
  logic              ready_out1;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;

  modport master (
    output valid_in, selector, data_in, ready_out0, ready_out1,
    input  ready_in, data_out0, data_out1, valid_out0, valid_out1, count0, count1
  );

  modport slave (
    input  valid_in, selector, data_in, ready_out0, ready_out1,
    output ready_in, data_out0, data_out1, valid_out0, valid_out1, count0, count1
  );

endinterface

// File: rtl/demux_1a2_fifo_lane_fifo.sv
// One output lane: circular buffer with occupancy, zero-when-empty head and delivered-word counter.
module lane_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop_rdy,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic              wr_en;
  logic              rd_en;

  always_comb begin
    full  = (occ == FULL_OCC);
    valid = (occ != '0);
    rdata = valid ? mem[rd_ptr] : '0;
    // A full lane refuses the push even when it pops in the same cycle.
    wr_en = push & ~full;
    rd_en = valid & pop_rdy;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        count  <= count + CNT_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux_1a2_fifo.sv
// 1:2 stream demultiplexer: selector routes each accepted word to one of two lane FIFOs.
module demux_1a2_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_L,
  demux_1a2_fifo_if.slave       bus
);

  lane_e sel;
  logic  full0;
  logic  full1;
  logic  ready_int;
  logic  push0;
  logic  push1;

  always_comb begin
    sel       = lane_e'(bus.selector);
    ready_int = reset_L & ((sel == LANE1) ? ~full1 : ~full0);
    push0     = bus.valid_in & ready_int & (sel == LANE0);
    push1     = bus.valid_in & ready_int & (sel == LANE1);
  end

  assign bus.ready_in = ready_int;

  lane_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_lane0 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push0),
    .wdata   (bus.data_in),
    .pop_rdy (bus.ready_out0),
    .full    (full0),
    .valid   (bus.valid_out0),
    .rdata   (bus.data_out0),
    .count   (bus.count0)
  );

  lane_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_lane1 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push1),
    .wdata   (bus.data_in),
    .pop_rdy (bus.ready_out1),
    .full    (full1),
    .valid   (bus.valid_out1),
    .rdata   (bus.data_out1),
    .count   (bus.count1)
  );

endmodule

// File: tb/tb_demux_1a2_fifo.sv
// Bench for demux_1a2_fifo: queue-based lane model checked every cycle plus directed literal checks.
module tb_demux_1a2_fifo;

  localparam int unsigned DATA_W = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 6;

  logic clk = 1'b0;
  logic reset_L = 1'b0;

  demux_1a2_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  demux_1a2_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per lane, delivered counts as plain integers.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int unsigned cnt0 = 0;
  int unsigned cnt1 = 0;
  bit acc, p0, p1;

  always @(negedge reset_L) begin
    q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
  end

  always @(posedge clk) begin
    if (!reset_L) begin
      q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
    end else begin
      acc = bus.valid_in && ((bus.selector ? q1.size() : q0.size()) < DEPTH);
      p0  = (q0.size() != 0) && bus.ready_out0;
      p1  = (q1.size() != 0) && bus.ready_out1;
      if (p0) begin void'(q0.pop_front()); cnt0++; end
      if (p1) begin void'(q1.pop_front()); cnt1++; end
      if (acc) begin
        if (bus.selector) q1.push_back(bus.data_in);
        else              q0.push_back(bus.data_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid0", 32'(bus.valid_out0), 32'(q0.size() != 0));
    chk("m_valid1", 32'(bus.valid_out1), 32'(q1.size() != 0));
    chk("m_data0",  32'(bus.data_out0),  (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    chk("m_data1",  32'(bus.data_out1),  (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
    chk("m_count0", 32'(bus.count0),     32'(CNT_W'(cnt0)));
    chk("m_count1", 32'(bus.count1),     32'(CNT_W'(cnt1)));
    chk("m_ready_in", 32'(bus.ready_in),
        32'(reset_L && ((bus.selector ? q1.size() : q0.size()) < DEPTH)));
  end

  task automatic set_in(input logic v, input logic s, input logic [DATA_W-1:0] d,
                        input logic r0, input logic r1);
    bus.valid_in   = v;
    bus.selector   = s;
    bus.data_in    = d;
    bus.ready_out0 = r0;
    bus.ready_out1 = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic s, input logic [DATA_W-1:0] d,
                     input logic r0, input logic r1);
    set_in(v, s, d, r0, r1);
    tick();
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    reset_L = 1'b0;
    tick(); tick();
    chk("rst_valid0", 32'(bus.valid_out0), 32'd0);
    chk("rst_valid1", 32'(bus.valid_out1), 32'd0);
    chk("rst_data0",  32'(bus.data_out0),  32'd0);
    chk("rst_count0", 32'(bus.count0),     32'd0);
    chk("rst_ready",  32'(bus.ready_in),   32'd0);

    reset_L = 1'b1;
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    chk("first_valid0", 32'(bus.valid_out0), 32'd1);
    chk("first_data0",  32'(bus.data_out0),  32'h2);
    chk("first_valid1", 32'(bus.valid_out1), 32'd0);

    // Alternating lanes with both consumers ready
    do_reset();
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    chk("alt_data0_a", 32'(bus.data_out0), 32'h1);
    cyc(1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    chk("alt_data1_a", 32'(bus.data_out1), 32'h3);
    chk("alt_valid0_gone", 32'(bus.valid_out0), 32'd0);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    chk("alt_data0_b", 32'(bus.data_out0), 32'h2);
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    chk("alt_data1_b", 32'(bus.data_out1), 32'h0);
    chk("alt_valid1_b", 32'(bus.valid_out1), 32'd1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    chk("alt_count0", 32'(bus.count0), 32'd2);
    chk("alt_count1", 32'(bus.count1), 32'd2);

    // Back-pressure on lane 1
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    #1;
    chk("bp_ready_full", 32'(bus.ready_in), 32'd0);
    tick();
    chk("bp_head1", 32'(bus.data_out1), 32'h1);
    bus.selector = 1'b0;
    #1;
    chk("bp_ready_switch", 32'(bus.ready_in), 32'd1);

    // Full lane 0: pop and refused push in the same cycle
    cyc(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    #1;
    chk("fp_ready", 32'(bus.ready_in), 32'd0);
    tick();
    chk("fp_valid0", 32'(bus.valid_out0), 32'd1);
    chk("fp_head0",  32'(bus.data_out0),  32'h1);
    chk("fp_ready_back", 32'(bus.ready_in), 32'd1);
    set_in(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("fp_empty0", 32'(bus.valid_out0), 32'd0);

    // Counter wrap on lane 0, lane 1 holds count 1
    do_reset();
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk("wrap_count1_pre", 32'(bus.count1), 32'd1);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, DATA_W'(i), 1'b1, 1'b0);
    end
    chk("wrap_count0_63", 32'(bus.count0), 32'd63);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("wrap_count0_0", 32'(bus.count0), 32'd0);
    chk("wrap_count1",   32'(bus.count1), 32'd1);
    chk("wrap_empty0",   32'(bus.valid_out0), 32'd0);

    // Asynchronous reset between edges
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("ar_pre_valid0", 32'(bus.valid_out0), 32'd1);
    chk("ar_pre_valid1", 32'(bus.valid_out1), 32'd1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("ar_valid0", 32'(bus.valid_out0), 32'd0);
    chk("ar_valid1", 32'(bus.valid_out1), 32'd0);
    chk("ar_data0",  32'(bus.data_out0),  32'd0);
    chk("ar_data1",  32'(bus.data_out1),  32'd0);
    chk("ar_count0", 32'(bus.count0),     32'd0);
    chk("ar_count1", 32'(bus.count1),     32'd0);
    chk("ar_ready",  32'(bus.ready_in),   32'd0);
    tick();
    reset_L = 1'b1;
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
